// File: rtl/trace_mem_ctrl_pkg.sv
// Shared constants and state encoding for the Data Trace Buffer memory side.
package trace_mem_ctrl_pkg;

  localparam int unsigned TRB_WIDTH     = 32;
  localparam int unsigned TRB_MEM_DEPTH = 16;
  localparam int unsigned TRB_DLY_BITS  = $clog2(TRB_MEM_DEPTH) + 1;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    POST,
    DONE,
    STREAM
  } trb_state_e;

endpackage

// File: rtl/trace_mem_ram.sv
// Simple dual-port RAM: synchronous write, asynchronous read (read-before-write).
module trace_mem_ram #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       FPGA_CLK_I,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]           wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]           rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Word write; contents are not reset.
  always_ff @(posedge FPGA_CLK_I) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/trace_mem_ctrl.sv
// Memory-side responder of the Data Trace Buffer: circular trace capture with
// post-trigger delay and host drain, or host-filled FIFO feeding the tracer.
module trace_mem_ctrl
  import trace_mem_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH    = TRB_WIDTH,
  parameter int unsigned DEPTH    = TRB_MEM_DEPTH,
  parameter int unsigned DLY_BITS = $clog2(DEPTH) + 1
) (
  input  logic                FPGA_CLK_I,
  input  logic                RST_NI,
  input  logic                EN_I,
  input  logic                MODE_I,
  input  logic                TRG_EVENT_I,
  input  logic [DLY_BITS-1:0] TRG_DELAY_I,
  output logic                TRG_DELAYED_O,
  input  logic                STORE_I,
  input  logic [WIDTH-1:0]    DATA_I,
  input  logic                REQ_I,
  output logic                LOAD_O,
  output logic [WIDTH-1:0]    DATA_O,
  input  logic [WIDTH-1:0]    HOST_WDATA_I,
  input  logic                HOST_WVALID_I,
  output logic                HOST_WREADY_O,
  output logic [WIDTH-1:0]    HOST_RDATA_O,
  output logic                HOST_RVALID_O,
  input  logic                HOST_RREADY_I,
  output logic [DLY_BITS-1:0] COUNT_O
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [DLY_BITS-1:0] DEPTH_C = DLY_BITS'(DEPTH);

  trb_state_e          state_q, state_n;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_n;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_n;
  logic [DLY_BITS-1:0] count_q, count_n;
  logic [DLY_BITS-1:0] dly_cnt_q, dly_cnt_n;
  logic [DLY_BITS-1:0] dly_lim;
  logic                pending_q, pending_n;
  logic                trg_q, trg_n;
  logic                load_q, load_n;
  logic [WIDTH-1:0]    data_q, data_n;

  logic                mem_we;
  logic [WIDTH-1:0]    mem_wdata;
  logic [PTR_W-1:0]    mem_raddr;
  logic [WIDTH-1:0]    mem_rdata;
  logic                wr_acc;
  logic                pop;
  logic                byp;
  logic                rvalid_c;

  trace_mem_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .FPGA_CLK_I (FPGA_CLK_I),
    .we         (mem_we),
    .waddr      (wr_ptr_q),
    .wdata      (mem_wdata),
    .raddr      (mem_raddr),
    .rdata      (mem_rdata)
  );

  assign dly_lim = (TRG_DELAY_I > DEPTH_C) ? DEPTH_C : TRG_DELAY_I;

  // Read address: oldest slot while capturing, oldest captured word while draining, FIFO head in stream.
  always_comb begin
    mem_raddr = rd_ptr_q;
    if (state_q == PRE || state_q == POST) begin
      mem_raddr = wr_ptr_q;
    end else if (state_q == DONE) begin
      mem_raddr = wr_ptr_q - PTR_W'(count_q);
    end
  end

  // Next-state, pointer, counter and tracer-response logic.
  always_comb begin
    state_n   = state_q;
    wr_ptr_n  = wr_ptr_q;
    rd_ptr_n  = rd_ptr_q;
    count_n   = count_q;
    dly_cnt_n = dly_cnt_q;
    pending_n = pending_q;
    trg_n     = trg_q;
    load_n    = 1'b0;
    data_n    = data_q;
    mem_we    = 1'b0;
    mem_wdata = DATA_I;
    wr_acc    = 1'b0;
    pop       = 1'b0;
    byp       = 1'b0;

    case (state_q)
      IDLE: state_n = MODE_I ? STREAM : PRE;

      PRE, POST: begin
        if (REQ_I) begin
          load_n = 1'b1;
          data_n = mem_rdata;
        end
        if (state_q == POST && dly_cnt_q >= dly_lim) begin
          state_n = DONE;
          trg_n   = 1'b1;
        end else if (STORE_I) begin
          mem_we   = 1'b1;
          wr_ptr_n = wr_ptr_q + 1'b1;
          if (count_q != DEPTH_C) count_n = count_q + 1'b1;
          if (state_q == POST) begin
            dly_cnt_n = dly_cnt_q + 1'b1;
            if (dly_cnt_n >= dly_lim) begin
              state_n = DONE;
              trg_n   = 1'b1;
            end
          end
        end
        if (state_q == PRE && TRG_EVENT_I) begin
          state_n   = POST;
          dly_cnt_n = '0;
        end
      end

      DONE: begin
        if (count_q != '0 && HOST_RREADY_I) count_n = count_q - 1'b1;
      end

      STREAM: begin
        wr_acc = HOST_WVALID_I && (count_q < DEPTH_C);
        if (wr_acc) begin
          mem_we    = 1'b1;
          mem_wdata = HOST_WDATA_I;
          wr_ptr_n  = wr_ptr_q + 1'b1;
        end
        if (REQ_I || pending_q) begin
          pending_n = 1'b0;
          if (count_q != '0) begin
            pop      = 1'b1;
            load_n   = 1'b1;
            data_n   = mem_rdata;
            rd_ptr_n = rd_ptr_q + 1'b1;
          end else if (wr_acc) begin
            // Filling write answers the pending request directly.
            byp      = 1'b1;
            load_n   = 1'b1;
            data_n   = HOST_WDATA_I;
            rd_ptr_n = rd_ptr_q + 1'b1;
          end else begin
            pending_n = 1'b1;
          end
        end
        if (wr_acc && !(pop || byp)) begin
          count_n = count_q + 1'b1;
        end else if (pop && !wr_acc) begin
          count_n = count_q - 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase

    if (!EN_I) begin
      state_n   = IDLE;
      wr_ptr_n  = '0;
      rd_ptr_n  = '0;
      count_n   = '0;
      dly_cnt_n = '0;
      pending_n = 1'b0;
      trg_n     = 1'b0;
      load_n    = 1'b0;
      data_n    = '0;
      mem_we    = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge FPGA_CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      dly_cnt_q <= '0;
      pending_q <= 1'b0;
      trg_q     <= 1'b0;
      load_q    <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_n;
      wr_ptr_q  <= wr_ptr_n;
      rd_ptr_q  <= rd_ptr_n;
      count_q   <= count_n;
      dly_cnt_q <= dly_cnt_n;
      pending_q <= pending_n;
      trg_q     <= trg_n;
      load_q    <= load_n;
      data_q    <= data_n;
    end
  end

  // Outputs drop to zero as soon as the block is disabled.
  assign rvalid_c      = EN_I && (state_q == DONE) && (count_q != '0);
  assign HOST_RVALID_O = rvalid_c;
  assign HOST_RDATA_O  = rvalid_c ? mem_rdata : '0;
  assign HOST_WREADY_O = EN_I && (state_q == STREAM) && (count_q < DEPTH_C);
  assign TRG_DELAYED_O = EN_I && trg_q;
  assign LOAD_O        = EN_I && load_q;
  assign DATA_O        = EN_I ? data_q : '0;
  assign COUNT_O       = EN_I ? count_q : '0;

endmodule

// File: tb/tb_trace_mem_ctrl.sv
// Self-checking bench for trace_mem_ctrl: queue-based reference model with
// per-cycle compare, directed scenarios with literal expectations, random traffic.
module tb_trace_mem_ctrl;
  import trace_mem_ctrl_pkg::*;

  localparam int unsigned W  = TRB_WIDTH;
  localparam int          D  = TRB_MEM_DEPTH;
  localparam int unsigned DB = TRB_DLY_BITS;

  localparam int S_IDLE = 0, S_PRE = 1, S_POST = 2, S_DONE = 3, S_STREAM = 4;

  logic          FPGA_CLK_I, RST_NI, EN_I, MODE_I, TRG_EVENT_I;
  logic [DB-1:0] TRG_DELAY_I;
  logic          TRG_DELAYED_O, STORE_I, REQ_I, LOAD_O;
  logic [W-1:0]  DATA_I, DATA_O, HOST_WDATA_I, HOST_RDATA_O;
  logic          HOST_WVALID_I, HOST_WREADY_O, HOST_RVALID_O, HOST_RREADY_I;
  logic [DB-1:0] COUNT_O;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 0;

  trace_mem_ctrl dut (
    .FPGA_CLK_I    (FPGA_CLK_I),
    .RST_NI        (RST_NI),
    .EN_I          (EN_I),
    .MODE_I        (MODE_I),
    .TRG_EVENT_I   (TRG_EVENT_I),
    .TRG_DELAY_I   (TRG_DELAY_I),
    .TRG_DELAYED_O (TRG_DELAYED_O),
    .STORE_I       (STORE_I),
    .DATA_I        (DATA_I),
    .REQ_I         (REQ_I),
    .LOAD_O        (LOAD_O),
    .DATA_O        (DATA_O),
    .HOST_WDATA_I  (HOST_WDATA_I),
    .HOST_WVALID_I (HOST_WVALID_I),
    .HOST_WREADY_O (HOST_WREADY_O),
    .HOST_RDATA_O  (HOST_RDATA_O),
    .HOST_RVALID_O (HOST_RVALID_O),
    .HOST_RREADY_I (HOST_RREADY_I),
    .COUNT_O       (COUNT_O)
  );

  initial FPGA_CLK_I = 1'b0;
  always #5 FPGA_CLK_I = ~FPGA_CLK_I;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int           m_st = S_IDLE;
  logic [W-1:0] m_q[$];          // trace ring contents or stream FIFO, oldest first
  int           m_post = 0;
  bit           m_pend = 0;
  bit           m_trg = 0;
  bit           m_load = 0;
  logic [W-1:0] m_data = '0;
  bit           m_known = 1;

  task automatic m_clear();
    m_st = S_IDLE; m_q.delete(); m_post = 0; m_pend = 0;
    m_trg = 0; m_load = 0; m_data = '0; m_known = 1;
  endtask

  always @(posedge FPGA_CLK_I or negedge RST_NI) begin : model
    int lim;
    bit want, wacc;
    if (!RST_NI || !EN_I) begin
      m_clear();
    end else begin
      lim = (int'(TRG_DELAY_I) > D) ? D : int'(TRG_DELAY_I);
      m_load = 0;
      case (m_st)
        S_IDLE: m_st = MODE_I ? S_STREAM : S_PRE;
        S_PRE, S_POST: begin
          if (REQ_I) begin
            m_load = 1;
            if (m_q.size() == D) begin m_data = m_q[0]; m_known = 1; end
            else m_known = 0;
          end
          if (m_st == S_POST && m_post >= lim) begin
            m_st = S_DONE; m_trg = 1;
          end else if (STORE_I) begin
            m_q.push_back(DATA_I);
            if (m_q.size() > D) void'(m_q.pop_front());
            if (m_st == S_POST) begin
              m_post++;
              if (m_post >= lim) begin m_st = S_DONE; m_trg = 1; end
            end
          end
          if (m_st == S_PRE && TRG_EVENT_I) begin m_st = S_POST; m_post = 0; end
        end
        S_DONE: if (m_q.size() > 0 && HOST_RREADY_I) void'(m_q.pop_front());
        S_STREAM: begin
          want = REQ_I || m_pend;
          wacc = HOST_WVALID_I && (m_q.size() < D);
          if (want && m_q.size() > 0) begin
            m_data = m_q.pop_front(); m_known = 1; m_load = 1; m_pend = 0;
            if (wacc) m_q.push_back(HOST_WDATA_I);
          end else if (want && wacc) begin
            m_data = HOST_WDATA_I; m_known = 1; m_load = 1; m_pend = 0;
          end else begin
            if (want) m_pend = 1;
            if (wacc) m_q.push_back(HOST_WDATA_I);
          end
        end
        default: m_st = S_IDLE;
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge FPGA_CLK_I) begin : compare
    bit en;
    if (cmp_on) begin
      en = EN_I && RST_NI;
      check("trg", W'(TRG_DELAYED_O), W'(en && m_trg));
      check("load", W'(LOAD_O), W'(en && m_load));
      if (!en || m_known) check("data_o", DATA_O, en ? m_data : '0);
      check("count", W'(COUNT_O), en ? W'(m_q.size()) : '0);
      check("wready", W'(HOST_WREADY_O), W'(en && m_st == S_STREAM && m_q.size() < D));
      check("rvalid", W'(HOST_RVALID_O), W'(en && m_st == S_DONE && m_q.size() > 0));
      if (en && m_st == S_DONE && m_q.size() > 0) check("rdata", HOST_RDATA_O, m_q[0]);
      else check("rdata", HOST_RDATA_O, '0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge FPGA_CLK_I);
    #1;
  endtask

  task automatic enable(input bit mode);
    EN_I = 1'b0;
    step();
    MODE_I = mode;
    EN_I = 1'b1;
    step();
  endtask

  task automatic store(input logic [W-1:0] w);
    STORE_I = 1'b1;
    DATA_I  = w;
    step();
    STORE_I = 1'b0;
  endtask

  task automatic drain(input int n, input int first);
    HOST_RREADY_I = 1'b1;
    for (int k = 0; k < n; k++) begin
      check("drain_word", HOST_RDATA_O, W'(first + k));
      step();
    end
    check("drain_end_rvalid", W'(HOST_RVALID_O), '0);
    HOST_RREADY_I = 1'b0;
  endtask

  task automatic all_zero(input string tag);
    check({tag, "_trg"}, W'(TRG_DELAYED_O), '0);
    check({tag, "_load"}, W'(LOAD_O), '0);
    check({tag, "_data"}, DATA_O, '0);
    check({tag, "_count"}, W'(COUNT_O), '0);
    check({tag, "_wready"}, W'(HOST_WREADY_O), '0);
    check({tag, "_rvalid"}, W'(HOST_RVALID_O), '0);
    check({tag, "_rdata"}, HOST_RDATA_O, '0);
  endtask

  initial begin
    RST_NI = 1'b0; EN_I = 1'b0; MODE_I = 1'b0; TRG_EVENT_I = 1'b0; TRG_DELAY_I = '0;
    STORE_I = 1'b0; DATA_I = '0; REQ_I = 1'b0;
    HOST_WDATA_I = '0; HOST_WVALID_I = 1'b0; HOST_RREADY_I = 1'b0;
    #12;
    all_zero("reset");
    @(negedge FPGA_CLK_I);
    RST_NI = 1'b1;
    cmp_on = 1'b1;

    // Trace with delay 4, trigger after word 9.
    TRG_DELAY_I = DB'(4);
    enable(1'b0);
    for (int i = 0; i < 20; i++) begin
      store(W'(i));
      if (i == 12) check("trg_before_13", W'(TRG_DELAYED_O), '0);
      if (i == 13) check("trg_at_13", W'(TRG_DELAYED_O), W'(1));
      if (i == 9) begin TRG_EVENT_I = 1'b1; step(); end
    end
    check("t1_count", W'(COUNT_O), W'(14));
    drain(14, 0);

    // Wrap capture: 30 stores, trigger after 24, delay 3.
    TRG_EVENT_I = 1'b0;
    TRG_DELAY_I = DB'(3);
    enable(1'b0);
    for (int i = 0; i < 30; i++) begin
      store(W'(i));
      if (i == 24) begin TRG_EVENT_I = 1'b1; step(); end
    end
    check("t2_count", W'(COUNT_O), W'(16));
    drain(16, 12);

    // Read-before-write on a full ring.
    TRG_EVENT_I = 1'b0;
    TRG_DELAY_I = DB'(16);
    enable(1'b0);
    for (int i = 0; i < 16; i++) store(W'(i));
    STORE_I = 1'b1; DATA_I = W'(32'hAA); REQ_I = 1'b1;
    step();
    STORE_I = 1'b0; REQ_I = 1'b0;
    check("rbw_load", W'(LOAD_O), W'(1));
    check("rbw_data", DATA_O, '0);
    REQ_I = 1'b1;
    step();
    REQ_I = 1'b0;
    check("rbw_next_data", DATA_O, W'(1));
    step();
    check("rbw_load_low", W'(LOAD_O), '0);
    check("rbw_data_hold", DATA_O, W'(1));

    // Stream underflow with an absorbed second request.
    enable(1'b1);
    REQ_I = 1'b1;
    step();
    check("uf_no_load0", W'(LOAD_O), '0);
    step();
    REQ_I = 1'b0;
    check("uf_no_load1", W'(LOAD_O), '0);
    HOST_WVALID_I = 1'b1; HOST_WDATA_I = W'(32'h55);
    step();
    HOST_WVALID_I = 1'b0;
    check("uf_load", W'(LOAD_O), W'(1));
    check("uf_data", DATA_O, W'(32'h55));
    check("uf_count", W'(COUNT_O), '0);
    step();
    check("uf_no_extra", W'(LOAD_O), '0);

    // Stream full, then pop with a blocked write.
    for (int i = 0; i < 16; i++) begin
      HOST_WVALID_I = 1'b1; HOST_WDATA_I = W'(32'h100 + i);
      step();
    end
    check("full_wready", W'(HOST_WREADY_O), '0);
    check("full_count", W'(COUNT_O), W'(16));
    HOST_WDATA_I = W'(32'hDEAD); REQ_I = 1'b1;
    step();
    REQ_I = 1'b0; HOST_WVALID_I = 1'b0;
    check("full_pop_count", W'(COUNT_O), W'(15));
    check("full_pop_data", DATA_O, W'(32'h100));
    check("full_pop_wready", W'(HOST_WREADY_O), W'(1));

    // Asynchronous reset in POST.
    TRG_DELAY_I = DB'(8);
    enable(1'b0);
    for (int i = 0; i < 4; i++) store(W'(i));
    TRG_EVENT_I = 1'b1;
    step();
    store(W'(4));
    store(W'(5));
    check("post_count", W'(COUNT_O), W'(6));
    @(posedge FPGA_CLK_I);
    #3 RST_NI = 1'b0;
    #1 all_zero("async_rst");
    @(negedge FPGA_CLK_I);
    #2 RST_NI = 1'b1;
    TRG_EVENT_I = 1'b0;
    step();

    // Enable dropped in DONE (zero delay).
    TRG_DELAY_I = '0;
    enable(1'b0);
    for (int i = 0; i < 3; i++) store(W'(32'h70 + i));
    TRG_EVENT_I = 1'b1;
    step();
    step();
    check("done_trg", W'(TRG_DELAYED_O), W'(1));
    check("done_count", W'(COUNT_O), W'(3));
    check("done_rdata", HOST_RDATA_O, W'(32'h70));
    EN_I = 1'b0;
    #1 all_zero("en_drop");
    step();
    all_zero("en_drop_edge");
    TRG_EVENT_I = 1'b0;

    // Randomized traffic in both modes.
    for (int r = 0; r < 10; r++) begin
      TRG_EVENT_I = 1'b0;
      TRG_DELAY_I = DB'($urandom_range(0, 31));
      enable(1'($urandom_range(0, 1)));
      for (int c = 0; c < 300; c++) begin
        STORE_I       = ($urandom_range(0, 2) == 0);
        DATA_I        = $urandom;
        REQ_I         = ($urandom_range(0, 3) == 0);
        HOST_WVALID_I = 1'($urandom_range(0, 1));
        HOST_WDATA_I  = $urandom;
        HOST_RREADY_I = 1'($urandom_range(0, 1));
        MODE_I        = 1'($urandom_range(0, 1));
        if (!TRG_EVENT_I && $urandom_range(0, 39) == 0) TRG_EVENT_I = 1'b1;
        if ($urandom_range(0, 249) == 0) begin
          EN_I = 1'b0;
          TRG_EVENT_I = 1'b0;
        end else begin
          EN_I = 1'b1;
        end
        step();
      end
      STORE_I = 1'b0; REQ_I = 1'b0; HOST_WVALID_I = 1'b0; HOST_RREADY_I = 1'b0;
    end

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
